otter_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the Otter IOBUS, directly downstream of the CPU core.
- Consumes IOBUS_ADDR / IOBUS_OUT / IOBUS_WR from the core and buffers bytes in a FIFO.
- Serialises bytes as 8N1 frames on TX.
- Drives status read-data back toward the core's IOBUS_IN mux.

---
 rtl/otter_uart_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_otter_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_uart_tx.sv
// ---------------------------------------------------------------------------
// otter_uart_tx
//
// Memory-mapped 8N1 UART transmitter for the Otter IOBUS. Stores from the
// core to DATA_ADDR are queued in a small byte FIFO. A four-state FSM takes
// bytes from the FIFO and shifts them out LSB first on TX. A status word
// (FULL, EMPTY, BUSY, sticky OVF, count) can be read at STAT_ADDR. Writing
// STAT_ADDR with bit 3 set clears OVF.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous active-low reset
//   IOBUS_ADDR  in   [31:0] bus address
//   IOBUS_OUT   in   [31:0] bus write data (only [7:0] and [3] used)
//   IOBUS_WR    in   bus write strobe
//   RD_DATA     out  [31:0] status word when IOBUS_ADDR==STAT_ADDR, else 0
//   TX          out  serial line, idle high, registered
//   BUSY        out  FSM not idle or FIFO non-empty
// ---------------------------------------------------------------------------
module otter_uart_tx #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] DATA_ADDR  = 32'h1100_0040,
    parameter logic [31:0] STAT_ADDR  = 32'h1100_0044
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        TX,
    output logic        BUSY
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // One extra bit so that a completely full FIFO is distinguishable.
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            baud_done;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push_req;
    logic            push_ok;
    logic            ovf_set;
    logic            ovf_clr;
    logic [7:0]      head;
    logic [7:0]      count_byte;
    logic [31:0]     status;
    logic            unused_bits;

    // Only the byte lane and the OVF-clear bit of the write data matter.
    assign unused_bits = ^IOBUS_OUT[31:8];

    assign baud_done  = (baud_q == BAUD_LAST);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign head       = mem_q[rd_ptr_q];

    // The FIFO is popped exactly when the FSM loads a new byte: from IDLE
    // immediately, or at the last cycle of a stop bit for back-to-back frames.
    assign pop = !fifo_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_done));

    assign push_req = IOBUS_WR && (IOBUS_ADDR == DATA_ADDR);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok  = push_req && (!fifo_full || pop);
    assign ovf_set  = push_req && !push_ok;
    assign ovf_clr  = IOBUS_WR && (IOBUS_ADDR == STAT_ADDR) && IOBUS_OUT[3];

    // ------------------------------------------------------------------
    // FIFO bookkeeping and sticky overflow
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set has priority over a same-cycle clear.
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

    // Storage carries no reset; validity is tracked by count/pointers.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= IOBUS_OUT[7:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and bit timing
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = head;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (pop) begin
                        shift_d = head;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output. TX is computed from the upcoming state and registered,
    // so the line changes exactly at the edge that enters a new bit.
    // ------------------------------------------------------------------
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Low 8 bits of count; a 256-deep FIFO that is full reads back as 0.
    always_comb begin
        count_byte = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(CW)) count_byte[i] = count_q[i];
        end
    end

    assign BUSY    = (state_q != S_IDLE) || !fifo_empty;
    assign status  = {16'h0000, count_byte, 4'h0, ovf_q, BUSY, fifo_empty, fifo_full};
    assign RD_DATA = (IOBUS_ADDR == STAT_ADDR) ? status : 32'h0000_0000;
    assign TX      = tx_q;

endmodule

// File: tb/tb_otter_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_otter_uart_tx
//
// Bench for otter_uart_tx with CLK_DIV=4, FIFO_DEPTH=4. Stimulus pushes the
// byte each accepted store should produce onto a scoreboard queue; an
// independent monitor decodes frames from TX and compares against it.
// Status word and timing expectations are checked inline.
// ---------------------------------------------------------------------------
module tb_otter_uart_tx;

    localparam int          CDIV   = 4;
    localparam int          DEPTH  = 4;
    localparam int          FRAME  = 10 * CDIV;
    localparam logic [31:0] DATA_A = 32'h1100_0040;
    localparam logic [31:0] STAT_A = 32'h1100_0044;

    logic        CLK;
    logic        RST;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] RD_DATA;
    logic        TX;
    logic        BUSY;

    typedef struct {
        logic [7:0] data;
        bit         b2b;
        bit         aborted;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;
    int   pcnt;

    otter_uart_tx #(
        .CLK_DIV   (CDIV),
        .FIFO_DEPTH(DEPTH),
        .DATA_ADDR (DATA_A),
        .STAT_ADDR (STAT_A)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT (IOBUS_OUT),
        .IOBUS_WR  (IOBUS_WR),
        .RD_DATA   (RD_DATA),
        .TX        (TX),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial pcnt = 0;
    always @(posedge CLK) pcnt <= pcnt + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        @(posedge CLK);
        #1;
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = 32'h0;
        IOBUS_OUT  = 32'h0;
    endtask

    task automatic read_stat(input string name, input logic [31:0] exp);
        IOBUS_ADDR = STAT_A;
        #1;
        check32(name, RD_DATA, exp);
        IOBUS_ADDR = 32'h0;
    endtask

    task automatic expect_byte(input logic [7:0] d, input bit b2b, input bit aborted);
        exp_t e;
        e.data    = d;
        e.b2b     = b2b;
        e.aborted = aborted;
        exp_q.push_back(e);
    endtask

    // Frame monitor: samples TX on falling edges, decodes one 8N1 frame per
    // start bit and checks it against the head of the scoreboard.
    initial begin
        int         cyc;
        int         start;
        int         last_start;
        bit         aborted;
        bit         shape_ok;
        logic [CDIV-1:0] smp [10];
        logic [7:0] byte_v;
        exp_t       e;
        cyc        = 0;
        last_start = -1000;
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST === 1'b1 && TX === 1'b0) begin
                start   = cyc;
                aborted = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < CDIV; s++) begin
                        if (b != 0 || s != 0) begin
                            @(negedge CLK);
                            cyc++;
                        end
                        if (RST !== 1'b1) aborted = 1'b1;
                        smp[b][s] = TX;
                    end
                end
                shape_ok = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    if (smp[b] !== {CDIV{1'b0}} && smp[b] !== {CDIV{1'b1}}) shape_ok = 1'b0;
                end
                if (smp[0] !== {CDIV{1'b0}}) shape_ok = 1'b0;
                if (smp[9] !== {CDIV{1'b1}}) shape_ok = 1'b0;
                for (int i = 0; i < 8; i++) byte_v[i] = smp[i+1][0];

                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected frame: got byte 0x%02h, expected no frame", byte_v);
                end else begin
                    e = exp_q.pop_front();
                    check32("frame aborted flag", {31'b0, aborted}, {31'b0, e.aborted});
                    if (!aborted && !e.aborted) begin
                        check32("frame shape", {31'b0, shape_ok}, 32'd1);
                        check32("frame data", {24'b0, byte_v}, {24'b0, e.data});
                        if (e.b2b) check32("back-to-back spacing", start - last_start, FRAME);
                    end
                end
                last_start = start;
            end
        end
    end

    initial begin
        int  busy_cycles;
        int  p2;
        int  lows;
        bit  drained;
        n_checks   = 0;
        n_errors   = 0;
        IOBUS_ADDR = 32'h0;
        IOBUS_OUT  = 32'h0;
        IOBUS_WR   = 1'b0;
        RST        = 1'b1;
        #2;
        RST = 1'b0;

        // Reset state
        tick(3);
        check32("reset TX", {31'b0, TX}, 32'd1);
        check32("reset BUSY", {31'b0, BUSY}, 32'd0);
        read_stat("reset status", 32'h0000_0002);
        RST = 1'b1;
        tick(2);

        // Single byte 0xA5: latency, frame, busy duration
        expect_byte(8'hA5, 1'b0, 1'b0);
        wr(DATA_A, 32'h0000_00A5);
        busy_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (i == 0) check32("TX high before start", {31'b0, TX}, 32'd1);
            if (i == 1) check32("TX start after one edge", {31'b0, TX}, 32'd0);
            if (BUSY) busy_cycles++;
            else break;
        end
        check32("BUSY duration", busy_cycles, 41);
        read_stat("idle status after frame", 32'h0000_0002);
        tick(1);

        // Burst of five: 0x11 pops on the second store, so 0x55 fits
        expect_byte(8'h11, 1'b0, 1'b0);
        wr(DATA_A, 32'h0000_0011);
        expect_byte(8'h22, 1'b1, 1'b0);
        wr(DATA_A, 32'h0000_0022);
        p2 = pcnt;
        expect_byte(8'h33, 1'b1, 1'b0);
        wr(DATA_A, 32'h0000_0033);
        expect_byte(8'h44, 1'b1, 1'b0);
        wr(DATA_A, 32'h0000_0044);
        expect_byte(8'h55, 1'b1, 1'b0);
        wr(DATA_A, 32'hFFFF_FF55);
        read_stat("full, no overflow", 32'h0000_0405);
        wr(DATA_A, 32'h0000_0066);
        read_stat("overflow on full", 32'h0000_040D);

        // OVF clear, re-set, and a write without bit 3
        wr(STAT_A, 32'h0000_0008);
        read_stat("OVF cleared", 32'h0000_0405);
        wr(DATA_A, 32'h0000_0077);
        read_stat("OVF re-set", 32'h0000_040D);
        wr(STAT_A, 32'h0000_0007);
        read_stat("OVF kept without bit3", 32'h0000_040D);
        wr(STAT_A, 32'h0000_0008);
        read_stat("OVF cleared again", 32'h0000_0405);

        // Push into a full FIFO on the very edge that pops (end of 0x11 STOP)
        while (pcnt < p2 + FRAME - 1) tick(1);
        read_stat("full before pop edge", 32'h0000_0405);
        expect_byte(8'h99, 1'b1, 1'b0);
        wr(DATA_A, 32'h0000_0099);
        read_stat("push in pop cycle accepted", 32'h0000_0405);

        drained = 1'b0;
        for (int i = 0; i < 8 * FRAME; i++) begin
            if (!BUSY && exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check32("burst drained in time", {31'b0, drained}, 32'd1);
        read_stat("status after burst", 32'h0000_0002);
        tick(1);

        // Asynchronous reset in the middle of data bit 3
        expect_byte(8'hC3, 1'b0, 1'b1);
        wr(DATA_A, 32'h0000_00C3);
        tick(18);
        RST = 1'b0;
        #1;
        check32("async reset TX", {31'b0, TX}, 32'd1);
        check32("async reset BUSY", {31'b0, BUSY}, 32'd0);
        tick(3);
        RST = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1) lows++;
        end
        check32("TX idle after reset", lows, 0);
        read_stat("status after reset", 32'h0000_0002);
        tick(1);

        // Other addresses
        IOBUS_ADDR = DATA_A;
        #1;
        check32("read at DATA_ADDR", RD_DATA, 32'h0);
        IOBUS_ADDR = 32'h1100_0000;
        #1;
        check32("read at other addr", RD_DATA, 32'h0);
        IOBUS_ADDR = 32'h0;
        tick(1);
        wr(32'h1100_0048, 32'h0000_005A);
        read_stat("status after foreign store", 32'h0000_0002);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1 || BUSY !== 1'b0) lows++;
        end
        check32("line quiet after foreign store", lows, 0);

        tick(2);
        check32("scoreboard empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
